// File: rtl/operand_bank_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_pkg
// Brief    : Shared defaults, FSM state encoding and stream-mode constants
//            for the ping-pong operand bank buffer.
// Revision : 1.0 - initial release
// ============================================================================
package operand_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUS_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_MAX_DIM    = DEF_BUS_WIDTH / DEF_DATA_WIDTH;

  // Streaming FSM: either idle or emitting vectors of the read bank.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Stream orientation: row vectors or column vectors (transpose).
  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

endpackage : operand_pkg
`default_nettype wire

// File: rtl/operand_bank_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_bank_buffer_if
// Brief    : Host write port, stream control and vector valid/ready port of
//            the operand bank buffer. master = host/consumer side,
//            slave = buffer side.
// Revision : 1.0 - initial release
// ============================================================================
interface operand_bank_buffer_if
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_WIDTH = $clog2(MAX_DIM + 1);

  // Host write / readback
  logic                  wr_en_i;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic [BUS_WIDTH-1:0]  wr_data_i;
  logic [MAX_DIM-1:0]    wr_strb_i;
  logic [BUS_WIDTH-1:0]  rd_data_o;

  // Bank / stream control
  logic                  commit_i;
  logic                  start_i;
  logic                  mode_i;
  logic [DIM_WIDTH-1:0]  dim_i;

  // Vector stream
  logic                  vec_valid_o;
  logic                  vec_ready_i;
  logic [BUS_WIDTH-1:0]  vec_data_o;
  logic [DIM_WIDTH-1:0]  vec_idx_o;
  logic                  vec_last_o;

  // Status
  logic                  busy_o;
  logic                  bank_sel_o;
  logic                  commit_pend_o;
  logic                  err_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    output commit_i, start_i, mode_i, dim_i, vec_ready_i,
    input  rd_data_o, vec_valid_o, vec_data_o, vec_idx_o, vec_last_o,
    input  busy_o, bank_sel_o, commit_pend_o, err_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    input  commit_i, start_i, mode_i, dim_i, vec_ready_i,
    output rd_data_o, vec_valid_o, vec_data_o, vec_idx_o, vec_last_o,
    output busy_o, bank_sel_o, commit_pend_o, err_o
  );

endinterface : operand_bank_buffer_if
`default_nettype wire

// File: rtl/operand_bank_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module   : operand_bank
// Brief    : One MAX_DIM x MAX_DIM operand bank. Per-row write enable with
//            per-element strobes, all rows visible combinationally, cleared
//            by asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module operand_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [MAX_DIM-1:0]           row_we_i,
  input  logic [BUS_WIDTH-1:0]         wr_data_i,
  input  logic [MAX_DIM-1:0]           wr_strb_i,
  output logic [MAX_DIM*BUS_WIDTH-1:0] rows_o
);

  logic [BUS_WIDTH-1:0] mem_q [MAX_DIM];

  // Strobed element-wise row update; reset zeroes the whole bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int e = 0; e < MAX_DIM; e++) begin
          if (row_we_i[r] && wr_strb_i[e]) begin
            mem_q[r][e*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  generate
    for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
      assign rows_o[r*BUS_WIDTH +: BUS_WIDTH] = mem_q[r];
    end
  endgenerate

endmodule : operand_bank
`default_nettype wire

// File: rtl/operand_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : operand_bank_buffer
// Brief    : Ping-pong operand store. Host fills the write bank while the
//            committed read bank is streamed as row or column vectors.
// Revision : 1.0 - initial release
// ============================================================================
module operand_bank_buffer
  import operand_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  operand_bank_buffer_if.slave bus
);

  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_WIDTH = $clog2(MAX_DIM + 1);
  localparam int ROWS_W    = MAX_DIM * BUS_WIDTH;

  state_e                 state_q, state_d;
  logic                   bank_sel_q, bank_sel_d;
  logic                   pend_q, pend_d;
  logic                   mode_q, mode_d;
  logic [DIM_WIDTH-1:0]   dim_q, dim_d;
  logic [DIM_WIDTH-1:0]   idx_q, idx_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [MAX_DIM-1:0]     w_row_we;
  logic [MAX_DIM-1:0]     w_we0, w_we1;
  logic [ROWS_W-1:0]      w_rows0, w_rows1, w_src;
  logic [BUS_WIDTH-1:0]   w_rd;
  logic                   w_hs, w_hs_last, w_dim_ok;
  logic [DIM_WIDTH-1:0]   w_k, w_dim;
  logic                   w_mode, w_k_last;
  logic [BUS_WIDTH-1:0]   w_vec;

  // Host row decode; out-of-range addresses match no row and are dropped.
  always_comb begin
    w_row_we = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      if (bus.wr_en_i && (bus.wr_addr_i == ADDR_WIDTH'(r))) begin
        w_row_we[r] = 1'b1;
      end
    end
  end

  // Only the bank opposite the read bank ever sees a write enable.
  assign w_we0 = bank_sel_q ? w_row_we : '0;
  assign w_we1 = bank_sel_q ? '0 : w_row_we;

  operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH),
    .MAX_DIM    (MAX_DIM)
  ) u_bank0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .row_we_i  (w_we0),
    .wr_data_i (bus.wr_data_i),
    .wr_strb_i (bus.wr_strb_i),
    .rows_o    (w_rows0)
  );

  operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH),
    .MAX_DIM    (MAX_DIM)
  ) u_bank1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .row_we_i  (w_we1),
    .wr_data_i (bus.wr_data_i),
    .wr_strb_i (bus.wr_strb_i),
    .rows_o    (w_rows1)
  );

  // Combinational readback of the write bank; zero for out-of-range rows.
  always_comb begin
    w_rd = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      if (bus.wr_addr_i == ADDR_WIDTH'(r)) begin
        w_rd = bank_sel_q ? w_rows0[r*BUS_WIDTH +: BUS_WIDTH]
                          : w_rows1[r*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  assign w_hs      = (state_q == STREAM) && bus.vec_ready_i;
  assign w_hs_last = w_hs && last_q;
  assign w_dim_ok  = (bus.dim_i != '0) && (bus.dim_i <= DIM_WIDTH'(MAX_DIM));

  // Bank swap: immediate in IDLE, deferred to the last handshake in STREAM.
  always_comb begin
    bank_sel_d = bank_sel_q;
    pend_d     = pend_q;
    if (state_q == IDLE) begin
      if (bus.commit_i) begin
        bank_sel_d = ~bank_sel_q;
      end
    end else if (w_hs_last) begin
      if (pend_q || bus.commit_i) begin
        bank_sel_d = ~bank_sel_q;
      end
      pend_d = 1'b0;
    end else if (bus.commit_i) begin
      pend_d = 1'b1;
    end
  end

  // Parameters of the next vector to load: the first one on start, else idx+1.
  always_comb begin
    w_k    = '0;
    w_mode = bus.mode_i;
    w_dim  = bus.dim_i;
    if (state_q == STREAM) begin
      w_k    = idx_q + DIM_WIDTH'(1);
      w_mode = mode_q;
      w_dim  = dim_q;
    end
  end

  assign w_k_last = (w_k == (w_dim - DIM_WIDTH'(1)));

  // Source bank follows the post-edge select so a same-cycle commit+start
  // streams the freshly committed bank.
  assign w_src = bank_sel_d ? w_rows1 : w_rows0;

  // Row/column gather with elements beyond the active dimension forced to 0.
  always_comb begin
    w_vec = '0;
    for (int j = 0; j < MAX_DIM; j++) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int e = 0; e < MAX_DIM; e++) begin
          if ((j < int'(w_dim)) &&
              (((w_mode == MODE_ROW) && (r == int'(w_k)) && (e == j)) ||
               ((w_mode == MODE_COL) && (r == j) && (e == int'(w_k))))) begin
            w_vec[j*DATA_WIDTH +: DATA_WIDTH] = w_src[r*BUS_WIDTH + e*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Stream FSM next-state and registered vector outputs.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dim_d   = dim_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (w_dim_ok) begin
            state_d = STREAM;
            mode_d  = bus.mode_i;
            dim_d   = bus.dim_i;
            idx_d   = '0;
            data_d  = w_vec;
            last_d  = w_k_last;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_hs) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            idx_d  = w_k;
            data_d = w_vec;
            last_d = w_k_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bank_sel_q <= 1'b0;
      pend_q     <= 1'b0;
      mode_q     <= MODE_ROW;
      dim_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      dim_q      <= dim_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign bus.rd_data_o     = w_rd;
  assign bus.vec_valid_o   = (state_q == STREAM);
  assign bus.busy_o        = (state_q == STREAM);
  assign bus.vec_data_o    = data_q;
  assign bus.vec_idx_o     = idx_q;
  assign bus.vec_last_o    = last_q && (state_q == STREAM);
  assign bus.bank_sel_o    = bank_sel_q;
  assign bus.commit_pend_o = pend_q;
  assign bus.err_o         = err_q;

endmodule : operand_bank_buffer
`default_nettype wire

// File: tb/tb_operand_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_bank_buffer
// Brief    : Directed, table-driven bench for operand_bank_buffer
//            (DATA_WIDTH=32, BUS_WIDTH=64, MAX_DIM=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_bank_buffer;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ctl = {wr_en, commit, start, mode, ready}
  // flg = {valid, last, busy, bank_sel, commit_pend, err} expected after edge
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  strb;
    logic [1:0]  dim;
    logic [5:0]  flg;
    logic [63:0] e_data;
    logic [1:0]  e_idx;
    logic [63:0] e_rd;
  } vec_t;

  operand_bank_buffer_if #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32)) bus ();

  operand_bank_buffer #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [1:0] strb,
                              input logic [1:0] dim, input logic [5:0] flg,
                              input logic [63:0] e_data, input logic [1:0] e_idx,
                              input logic [63:0] e_rd);
    vec_t v;
    v.ctl = ctl; v.addr = addr; v.wdata = wdata; v.strb = strb; v.dim = dim;
    v.flg = flg; v.e_data = e_data; v.e_idx = e_idx; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h want %h", tag, fld, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [5:0] flg, input logic [63:0] data,
                           input logic [1:0] idx, input logic [63:0] rd);
    cmp(tag, "valid", 64'(bus.vec_valid_o),   64'(flg[5]));
    cmp(tag, "last",  64'(bus.vec_last_o),    64'(flg[4]));
    cmp(tag, "busy",  64'(bus.busy_o),        64'(flg[3]));
    cmp(tag, "bank",  64'(bus.bank_sel_o),    64'(flg[2]));
    cmp(tag, "pend",  64'(bus.commit_pend_o), 64'(flg[1]));
    cmp(tag, "err",   64'(bus.err_o),         64'(flg[0]));
    cmp(tag, "rd",    bus.rd_data_o,          rd);
    if (flg[5]) begin
      cmp(tag, "data", bus.vec_data_o,       data);
      cmp(tag, "idx",  64'(bus.vec_idx_o),   64'(idx));
    end
  endtask

  task automatic apply(input vec_t v);
    bus.wr_en_i     = v.ctl[4];
    bus.commit_i    = v.ctl[3];
    bus.start_i     = v.ctl[2];
    bus.mode_i      = v.ctl[1];
    bus.vec_ready_i = v.ctl[0];
    bus.wr_addr_i   = v.addr;
    bus.wr_data_i   = v.wdata;
    bus.wr_strb_i   = v.strb;
    bus.dim_i       = v.dim;
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    apply(v);
    @(posedge clk);
    #1;
    check_out(tag, v.flg, v.e_data, v.e_idx, v.e_rd);
  endtask

  localparam logic [63:0] R0  = 64'h00000002_00000001;
  localparam logic [63:0] R1  = 64'h00000004_00000003;
  localparam logic [63:0] AB  = 64'hAAAAAAAA_00000001;
  localparam logic [63:0] Z   = 64'h0;

  vec_t tbl[20];

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    apply(mk(5'b00000, 32'd0, Z, 2'b00, 2'd0, 6'b0, Z, 2'd0, Z));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("reset0", 6'b000000, Z, 2'd0, Z);
    bus.wr_addr_i = 32'd1;
    #1;
    check_out("reset1", 6'b000000, Z, 2'd0, Z);

    // ---------------- directed table ----------------
    tbl[0]  = mk(5'b10000, 32'd0, R0, 2'b11, 2'd0, 6'b000000, Z, 2'd0, R0);
    tbl[1]  = mk(5'b10000, 32'd1, R1, 2'b11, 2'd0, 6'b000000, Z, 2'd0, R1);
    tbl[2]  = mk(5'b01000, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[3]  = mk(5'b00101, 32'd0, Z,  2'b00, 2'd2, 6'b101100, R0, 2'd0, Z);
    tbl[4]  = mk(5'b00001, 32'd0, Z,  2'b00, 2'd0, 6'b111100, R1, 2'd1, Z);
    tbl[5]  = mk(5'b00001, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[6]  = mk(5'b00111, 32'd0, Z,  2'b00, 2'd2, 6'b101100, 64'h00000003_00000001, 2'd0, Z);
    tbl[7]  = mk(5'b00001, 32'd0, Z,  2'b00, 2'd0, 6'b111100, 64'h00000004_00000002, 2'd1, Z);
    tbl[8]  = mk(5'b00001, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[9]  = mk(5'b00101, 32'd0, Z,  2'b00, 2'd1, 6'b111100, 64'h00000000_00000001, 2'd0, Z);
    tbl[10] = mk(5'b00001, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[11] = mk(5'b00100, 32'd0, Z,  2'b00, 2'd0, 6'b000101, Z, 2'd0, Z);
    tbl[12] = mk(5'b00000, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[13] = mk(5'b00100, 32'd0, Z,  2'b00, 2'd3, 6'b000101, Z, 2'd0, Z);
    tbl[14] = mk(5'b00000, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[15] = mk(5'b10000, 32'd0, R0, 2'b11, 2'd0, 6'b000100, Z, 2'd0, R0);
    tbl[16] = mk(5'b10000, 32'd0, 64'hAAAAAAAA_BBBBBBBB, 2'b10, 2'd0, 6'b000100, Z, 2'd0, AB);
    tbl[17] = mk(5'b10000, 32'd5, 64'hFFFFFFFF_FFFFFFFF, 2'b11, 2'd0, 6'b000100, Z, 2'd0, Z);
    tbl[18] = mk(5'b00000, 32'd0, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, AB);
    tbl[19] = mk(5'b00000, 32'd1, Z,  2'b00, 2'd0, 6'b000100, Z, 2'd0, Z);

    for (int i = 0; i < 20; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // ---------------- stall with deferred commit ----------------
    step("stall_start", mk(5'b00100, 32'd0, Z, 2'b00, 2'd2, 6'b101100, R0, 2'd0, AB));
    step("stall_cmt",   mk(5'b01000, 32'd0, Z, 2'b00, 2'd0, 6'b101110, R0, 2'd0, AB));
    step("stall_hold1", mk(5'b00000, 32'd0, Z, 2'b00, 2'd0, 6'b101110, R0, 2'd0, AB));
    step("stall_hold2", mk(5'b01000, 32'd0, Z, 2'b00, 2'd0, 6'b101110, R0, 2'd0, AB));
    step("stall_v1",    mk(5'b00001, 32'd0, Z, 2'b00, 2'd0, 6'b111110, R1, 2'd1, AB));
    step("stall_end",   mk(5'b00001, 32'd0, Z, 2'b00, 2'd0, 6'b000000, Z, 2'd0, R0));

    // ---------------- commit + start in the same cycle ----------------
    step("cs_start", mk(5'b01101, 32'd0, Z, 2'b00, 2'd2, 6'b101100, R0, 2'd0, AB));
    step("cs_v1",    mk(5'b00101, 32'd0, Z, 2'b00, 2'd0, 6'b111100, R1, 2'd1, AB));
    step("cs_end",   mk(5'b00001, 32'd0, Z, 2'b00, 2'd0, 6'b000100, Z, 2'd0, AB));

    // ---------------- asynchronous reset mid-stream ----------------
    step("rst_start", mk(5'b00100, 32'd0, Z, 2'b00, 2'd2, 6'b101100, R0, 2'd0, AB));
    step("rst_cmt",   mk(5'b01000, 32'd0, Z, 2'b00, 2'd0, 6'b101110, R0, 2'd0, AB));
    @(negedge clk);
    apply(mk(5'b00000, 32'd0, Z, 2'b00, 2'd0, 6'b0, Z, 2'd0, Z));
    rst = 1'b1;
    #1;
    check_out("rst_async", 6'b000000, Z, 2'd0, Z);
    @(negedge clk);
    rst = 1'b0;
    step("rst_after", mk(5'b00000, 32'd0, Z, 2'b00, 2'd0, 6'b000000, Z, 2'd0, Z));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_operand_bank_buffer
`default_nettype wire

// File: doc/operand_bank_buffer.md
# operand_bank_buffer

Double-buffered (ping-pong) operand store for the matrix-multiply datapath, the parametrised successor of the single-bank operand register file. The host writes a full operand matrix, one bus-wide row at a time with per-element strobes, into the write bank. The compute core meanwhile streams the committed read bank out as row or column vectors over a valid/ready port. A commit swaps the banks without stalling the host.

## Interface
- DATA_WIDTH, 32, width of one matrix element
- BUS_WIDTH, 64, width of one row/vector; must be a multiple of DATA_WIDTH
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, matrix is MAX_DIM x MAX_DIM (derived, not overridden)
- ADDR_WIDTH, 32, row address width
- DIM_WIDTH, $clog2(MAX_DIM+1), width of dim_i
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wr_en_i  in  1  write strobed row of the write bank
- wr_addr_i  in  ADDR_WIDTH  row index for write and host readback
- wr_data_i  in  BUS_WIDTH  row data; element e at [e*DATA_WIDTH +: DATA_WIDTH]
- wr_strb_i  in  MAX_DIM  per-element write enable
- rd_data_o  out  BUS_WIDTH  asynchronous readback of write-bank row wr_addr_i
- commit_i  in  1  pulse: publish write bank as read bank
- start_i  in  1  pulse: begin streaming the read bank
- mode_i  in  1  0 = row vectors, 1 = column vectors (transpose); sampled at start
- dim_i  in  DIM_WIDTH  active dimension 1..MAX_DIM; sampled at start
- vec_valid_o  out  1  vector valid
- vec_ready_i  in  1  consumer ready
- vec_data_o  out  BUS_WIDTH  vector data
- vec_idx_o  out  DIM_WIDTH  vector index 0..dim-1
- vec_last_o  out  1  final vector of the stream
- busy_o  out  1  stream in progress
- bank_sel_o  out  1  current read bank (write bank = ~bank_sel_o)
- commit_pend_o  out  1  commit deferred until the stream ends
- err_o  out  1  one-cycle pulse on an illegal start

## Operation
- Reset: both banks zero; bank_sel_o=0; FSM IDLE; every output 0 except rd_data_o, which shows the zeroed bank.
- Write: when wr_en_i=1 and wr_addr_i<MAX_DIM, element e of the write-bank row is updated if wr_strb_i[e]=1. When wr_addr_i>=MAX_DIM, the write is ignored and rd_data_o=0.
- No port can ever write the read bank.
- FSM IDLE -> STREAM on start_i when 1<=dim_i<=MAX_DIM. On that edge mode, dim and the index counter (0) are latched.
- start_i with dim_i=0 or dim_i>MAX_DIM: the request is ignored and err_o pulses. start_i in STREAM is ignored with no error.
- STREAM, mode 0: vector k = read-bank row k.
- STREAM, mode 1: element j of vector k = read-bank row j, element k.
- Elements j>=dim are forced to 0 in both modes.
- STREAM -> IDLE on the handshake (valid&ready) of vector dim-1.
- Commit in IDLE: bank_sel_o toggles on the next edge.
- Commit in STREAM: commit_pend_o is set. The swap happens on the edge of the last handshake, which also clears the pending flag.
- Repeated commits while pending collapse into one swap.
- commit_i and start_i in the same IDLE cycle: the swap takes effect and the stream reads the newly committed bank.

## Timing
- Write latency is 1 cycle; rd_data_o is combinational from storage and reflects a write on the following cycle.
- First vector: vec_valid_o rises the cycle after the accepted start_i, with registered outputs.
- One vector per cycle while vec_ready_i=1, so full throughput is dim cycles.
- While valid&!ready, vec_data_o, vec_idx_o and vec_last_o hold stable.
- Valid never drops without a handshake, except on reset.
- vec_last_o is high exactly when vec_idx_o=dim-1 and valid=1.
- busy_o is high from the cycle after start through the last-handshake cycle.
- A new start_i is accepted on the cycle busy_o is low.
- Reset mid-stream: valid, busy and pending clear immediately (asynchronously); banks are zeroed.

## Structure
- Package operand_pkg holds the DATA_WIDTH/BUS_WIDTH/MAX_DIM defaults, the FSM state enum (IDLE, STREAM) and the MODE_ROW/MODE_COL constants.
- Sub-module operand_bank, instantiated twice: MAX_DIM rows, strobed row write, asynchronous row read, asynchronous reset clear.
- The top level holds the FSM, the bank-select/commit logic and the transpose mux.

## Test plan
All scenarios use DATA_WIDTH=32, MAX_DIM=2.
- Reset -> all outputs 0, bank_sel_o=0, rd_data_o=0 for addr 0 and 1.
- Write row0=0x00000002_00000001 and row1=0x00000004_00000003 with strb=2'b11, commit, start mode 0 dim 2, ready=1 -> 0x00000002_00000001 (idx 0), then 0x00000004_00000003 (idx 1, last=1), then busy_o=0.
- Same data, mode 1 -> 0x00000003_00000001, then 0x00000004_00000002.
- Hold ready low 3 cycles mid-stream and pulse commit -> data held; commit_pend_o=1; bank_sel_o toggles on the last handshake edge.
- Write row0 with strb=2'b10 and data 0xAAAAAAAA_BBBBBBBB over 0x00000002_00000001 -> readback 0xAAAAAAAA_00000001.
- start dim=1 -> a single vector with the upper element 0 and last=1. start dim=0 -> err_o pulses and busy_o stays 0. Assert rst_i mid-stream -> valid drops the same cycle.
